multislope_runup: RTL and testbench

//  Parametrised successor to the run-up PWM generator of the multi-slope converter.
//  - Sequences one complete run-up: comparator-driven reference decision each period, selectable PWM mode.
//  - Counts positive and negative reference periods, then hands off to rundown with a done pulse.
//  - Sits between the siggen timing block and the integrator analogue switches.

---
 rtl/msc_pkg.sv | 17 +
 rtl/runup_period_timer.sv | 38 +++
 rtl/multislope_runup.sv | 210 +++++++++++++++++++++
 tb/tb_multislope_runup.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msc_pkg.sv
// Shared definitions for the multi-slope converter blocks:
// run-up FSM states, PWM mode codes and the default period.
package msc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } runup_state_e;

  localparam logic MODE_FULL  = 1'b0;
  localparam logic MODE_GUARD = 1'b1;

  // Clocks per run-up period minus one; also used by pwmgen and siggen.
  localparam int RUNUP_PERIOD_DEF = 249;

endpackage

// File: rtl/runup_period_timer.sv
// Run-up period counter: counts 0..PERIOD and wraps, held at 0 by clr_i.
// Ports: clk_i, rst_i (sync, active high), clr_i -> pcnt_o,
//        period_start_o (next cycle is pcnt 0), period_end_o (pcnt == PERIOD).
module runup_period_timer
  import msc_pkg::*;
#(
  parameter int PERIOD   = RUNUP_PERIOD_DEF,
  parameter int PERIOD_W = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  output logic [PERIOD_W-1:0] pcnt_o,
  output logic                period_start_o,
  output logic                period_end_o
);

  localparam logic [PERIOD_W-1:0] LAST = PERIOD_W'(PERIOD);

  logic [PERIOD_W-1:0] pcnt_q;
  logic [PERIOD_W-1:0] pcnt_d;

  assign period_end_o   = (pcnt_q == LAST);
  // Asserted whenever the next cycle begins a fresh period, so the
  // parent can register period-aligned outputs one cycle ahead.
  assign period_start_o = clr_i | period_end_o;
  assign pcnt_d         = period_start_o ? '0 : pcnt_q + 1'b1;
  assign pcnt_o         = pcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/multislope_runup.sv
// Multi-slope run-up sequencer: per-period comparator decision, PWM
// reference switch drive (full or guarded), pos/neg period counters.
// Ports: clk_i, rst_i (sync, active high), start_i, nper_i, mode_i,
//        comp_i (async) -> sw_in_o, sw_pos_o, sw_neg_o, busy_o, done_o,
//        pos_cnt_o, neg_cnt_o, ovf_o.
// Build option: define RUNUP_OVF_DET_EN for run-length overflow detection;
// otherwise ovf_o is tied low.
module multislope_runup
  import msc_pkg::*;
#(
  parameter int PERIOD   = RUNUP_PERIOD_DEF,
  parameter int PERIOD_W = 9,
  parameter int PULSE    = 62,
  parameter int CNT_W    = 20,
  parameter int MAX_RUN  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] nper_i,
  input  logic             mode_i,
  input  logic             comp_i,
  output logic             sw_in_o,
  output logic             sw_pos_o,
  output logic             sw_neg_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pos_cnt_o,
  output logic [CNT_W-1:0] neg_cnt_o,
  output logic             ovf_o
);

  localparam logic [PERIOD_W-1:0] WIN_LO = PERIOD_W'(PULSE);
  localparam logic [PERIOD_W-1:0] WIN_HI = PERIOD_W'(PERIOD - PULSE);

  if (2 * PULSE >= PERIOD || PERIOD >= (1 << PERIOD_W) || MAX_RUN < 1)
  begin : g_bad_cfg
    $error("multislope_runup: inconsistent parameters");
  end

  runup_state_e state_q, state_d;

  logic             comp_m_q, comp_s_q;
  logic [CNT_W-1:0] nper_q, nper_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] neg_q, neg_d;
  logic             mode_q, mode_d;
  logic             dec_q, dec_d;
  logic             sw_pos_q, sw_pos_d;
  logic             sw_neg_q, sw_neg_d;
  logic             sw_in_q, busy_q, done_q;
  logic             accept;
  logic             run_nx;
  logic             sw_on;
  logic             tmr_clr;
  logic             pstart, pend;
  logic [PERIOD_W-1:0] pcnt, pcnt_nx;

  assign tmr_clr = (state_q != ST_RUN);

  runup_period_timer #(
    .PERIOD  (PERIOD),
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (tmr_clr),
    .pcnt_o        (pcnt),
    .period_start_o(pstart),
    .period_end_o  (pend)
  );

  always_comb begin
    state_d = state_q;
    nper_d  = nper_q;
    per_d   = per_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          nper_d  = nper_i;
          mode_d  = mode_i;
          per_d   = '0;
          pos_d   = '0;
          neg_d   = '0;
          state_d = (nper_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pend) begin
          per_d = per_q + 1'b1;
          if (dec_q) begin
            if (neg_q != '1) neg_d = neg_q + 1'b1;
          end else begin
            if (pos_q != '1) pos_d = pos_q + 1'b1;
          end
          if (per_q == nper_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Switches are registered from next-cycle values so each switch
  // edge lines up exactly with the pcnt it belongs to.
  always_comb begin
    run_nx   = (state_d == ST_RUN);
    pcnt_nx  = pstart ? '0 : pcnt + 1'b1;
    dec_d    = (run_nx && pstart) ? comp_s_q : dec_q;
    sw_on    = run_nx &&
               ((mode_d == MODE_FULL) ||
                (mode_d == MODE_GUARD &&
                 pcnt_nx >= WIN_LO && pcnt_nx <= WIN_HI));
    sw_pos_d = sw_on & ~dec_d;
    sw_neg_d = sw_on & dec_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      comp_m_q <= 1'b0;
      comp_s_q <= 1'b0;
      nper_q   <= '0;
      per_q    <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      mode_q   <= MODE_FULL;
      dec_q    <= 1'b0;
      sw_pos_q <= 1'b0;
      sw_neg_q <= 1'b0;
      sw_in_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      comp_m_q <= comp_i;
      comp_s_q <= comp_m_q;
      nper_q   <= nper_d;
      per_q    <= per_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      mode_q   <= mode_d;
      dec_q    <= dec_d;
      sw_pos_q <= sw_pos_d;
      sw_neg_q <= sw_neg_d;
      sw_in_q  <= run_nx;
      busy_q   <= run_nx;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign sw_in_o   = sw_in_q;
  assign sw_pos_o  = sw_pos_q;
  assign sw_neg_o  = sw_neg_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pos_cnt_o = pos_q;
  assign neg_cnt_o = neg_q;

`ifdef RUNUP_OVF_DET_EN
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  // run_q == 0 marks "no decision yet" so the first period starts at 1.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    ovf_d  = ovf_q;
    if (accept) begin
      run_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ST_RUN && pend) begin
      if (run_q != '0 && dec_q == last_q) begin
        run_d = (run_q == RUN_LIM) ? run_q : run_q + 1'b1;
      end else begin
        run_d = RUN_W'(1);
      end
      last_d = dec_q;
      if (run_d == RUN_LIM) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q  <= '0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_multislope_runup.sv
// Scoreboard bench for multislope_runup: a period-level model queues
// per-cycle switch states and per-run results; a monitor checks them.
module tb_multislope_runup;

  localparam int PER  = 9;
  localparam int PW   = 4;
  localparam int PUL  = 2;
  localparam int CW   = 8;
  localparam int MAXR = 4;
  localparam int PL   = PER + 1;
`ifdef RUNUP_OVF_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit pos;
    bit neg;
    bit ovf;
  } cyc_t;

  typedef struct {
    int pos;
    int neg;
    bit ovf;
    int done_cyc;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          comp = 1'b0;
  logic [CW-1:0] nper = '0;
  logic          sw_in, sw_pos, sw_neg, busy, done, ovf;
  logic [CW-1:0] pos_cnt, neg_cnt;

  multislope_runup #(
    .PERIOD  (PER),
    .PERIOD_W(PW),
    .PULSE   (PUL),
    .CNT_W   (CW),
    .MAX_RUN (MAXR)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .nper_i   (nper),
    .mode_i   (mode),
    .comp_i   (comp),
    .sw_in_o  (sw_in),
    .sw_pos_o (sw_pos),
    .sw_neg_o (sw_neg),
    .busy_o   (busy),
    .done_o   (done),
    .pos_cnt_o(pos_cnt),
    .neg_cnt_o(neg_cnt),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   held_pos = 0;
  int   held_neg = 0;
  bit   held_ovf = 1'b0;
  bit   mon_en = 1'b0;
  bit   dq[$];
  cyc_t cq[$];
  res_t rq[$];
  cyc_t me;
  res_t mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("no_overlap", 32'(sw_pos & sw_neg), 0);
      if (busy) begin
        chk("done_in_busy", 32'(done), 0);
        if (cq.size() == 0) begin
          chk("busy_unexpected", 1, 0);
        end else begin
          me = cq.pop_front();
          chk("sw_in", 32'(sw_in), 1);
          chk("sw_pos", 32'(sw_pos), 32'(me.pos));
          chk("sw_neg", 32'(sw_neg), 32'(me.neg));
          chk("ovf_run", 32'(ovf), 32'(me.ovf));
        end
      end else begin
        if (done) begin
          if (rq.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            mr = rq.pop_front();
            chk("done_time", 32'(cyc), 32'(mr.done_cyc));
            chk("pos_cnt", 32'(pos_cnt), 32'(mr.pos));
            chk("neg_cnt", 32'(neg_cnt), 32'(mr.neg));
            chk("ovf_done", 32'(ovf), 32'(mr.ovf));
            held_pos = mr.pos;
            held_neg = mr.neg;
            held_ovf = mr.ovf;
          end
        end
        chk("idle_sw", 32'({sw_in, sw_pos, sw_neg}), 0);
        chk("held_pos", 32'(pos_cnt), 32'(held_pos));
        chk("held_neg", 32'(neg_cnt), 32'(held_neg));
        chk("held_ovf", 32'(ovf), 32'(held_ovf));
      end
    end
  end

  // One run-up of n periods using the decisions in dq.
  // abort >= 0 asserts reset at that busy cycle instead of finishing.
  task automatic run_up(input int n, input bit m, input int abort);
    int   run;
    bit   ov;
    bit   on;
    res_t r;
    cyc_t e;
    run = 0;
    ov = 1'b0;
    r.pos = 0;
    r.neg = 0;
    comp = (n > 0) ? dq[0] : 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < PL; c++) begin
        on = (m == 1'b0) || (c >= PUL && c <= PER - PUL);
        e.pos = on && !dq[k];
        e.neg = on && dq[k];
        e.ovf = OVF_EN && ov;
        if (abort < 0 || k * PL + c <= abort) cq.push_back(e);
      end
      run = (k > 0 && dq[k] == dq[k-1]) ? run + 1 : 1;
      if (run >= MAXR) ov = 1'b1;
      if (dq[k]) r.neg++;
      else r.pos++;
    end
    r.ovf = OVF_EN && ov;
    r.done_cyc = cyc + 1 + n * PL;
    if (abort < 0) rq.push_back(r);
    start = 1'b1;
    nper = CW'(n);
    mode = m;
    @(negedge clk);
    // This second pulse lands while busy or in DONE and must be ignored.
    nper = CW'($urandom_range(1, 9));
    mode = ~m;
    for (int c = 0; c < n * PL + 2; c++) begin
      if (c == abort) begin
        rst = 1'b1;
        held_pos = 0;
        held_neg = 0;
        held_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (c % PL == 5 && c / PL + 1 < n) comp = dq[c / PL + 1];
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input int n, input int kind);
    dq.delete();
    for (int k = 0; k < n; k++) begin
      case (kind)
        0: dq.push_back(1'b0);
        1: dq.push_back(1'b1);
        2: dq.push_back(k[0]);
        default: dq.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    fill(3, 0);
    run_up(3, 1'b0, -1);
    fill(2, 1);
    run_up(2, 1'b1, -1);
    fill(4, 2);
    run_up(4, 1'b0, -1);
    fill(4, 2);
    run_up(4, 1'b1, -1);
    fill(0, 0);
    run_up(0, 1'b0, -1);
    fill(6, 0);
    run_up(6, 1'b0, -1);
    fill(2, 2);
    run_up(2, 1'b0, -1);
    fill(5, 3);
    run_up(5, 1'b0, 15);
    fill(3, 3);
    run_up(3, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 7);
      fill(n, 3);
      run_up(n, 1'($urandom_range(0, 1)), -1);
    end

    repeat (5) @(negedge clk);
    chk("cycles_left", 32'(cq.size()), 0);
    chk("results_left", 32'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
